// File: rtl/rc4_encryptor.sv
// RC4 encryptor: initialises and key-schedules a shared 256-byte S RAM, then
// runs PRGA over a plaintext ROM and writes plaintext ^ keystream into a
// ciphertext RAM. The control handshake (start/ready/finish) is shared with
// rc4_cracker.
//
// Every S RAM access takes its own state, so the single port is never shared.
// Reads wait one cycle before the data is captured. KSA takes 6 cycles per
// index and PRGA takes 9 cycles per byte.
module rc4_encryptor #(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [23:0]       key,
  output logic              ready,
  output logic              finish,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_rdata,
  output logic [ADDR_W-1:0] pt_addr,
  input  logic [7:0]        pt_rdata,
  output logic [ADDR_W-1:0] ct_addr,
  output logic [7:0]        ct_wdata,
  output logic              ct_wren
);

  localparam logic [ADDR_W-1:0] LP_LAST_K = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    ST_K_RD_I,
    ST_K_CAP_I,
    ST_K_RD_J,
    ST_K_CAP_J,
    ST_K_WR_I,
    ST_K_WR_J,
    ST_P_RD_I,
    ST_P_CAP_I,
    ST_P_RD_J,
    ST_P_CAP_J,
    ST_P_WR_I,
    ST_P_WR_J,
    ST_P_RD_F,
    ST_P_CAP_F,
    ST_P_WR_CT,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [23:0]       r_key;
  logic [7:0]        r_i;
  logic [7:0]        r_j;
  logic [ADDR_W-1:0] r_k;
  logic [1:0]        r_kidx;   // i mod 3 during KSA
  logic [7:0]        r_si;
  logic [7:0]        r_sj;
  logic [7:0]        r_ct;
  logic [7:0]        w_kbyte;

  // Key byte selected by i mod 3: k[0] is the most significant byte.
  always_comb begin
    w_kbyte = r_key[7:0];
    case (r_kidx)
      2'd0:    w_kbyte = r_key[23:16];
      2'd1:    w_kbyte = r_key[15:8];
      default: w_kbyte = r_key[7:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and memory-port outputs decoded from the current state.
  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    finish      = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wren      = 1'b0;
    pt_addr     = '0;
    ct_addr     = '0;
    ct_wdata    = '0;
    ct_wren     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        s_addr  = r_i;
        s_wdata = r_i;
        s_wren  = 1'b1;
        if (r_i == 8'd255) w_state_nxt = ST_K_RD_I;
      end
      ST_K_RD_I: begin
        s_addr      = r_i;
        w_state_nxt = ST_K_CAP_I;
      end
      ST_K_CAP_I: w_state_nxt = ST_K_RD_J;
      ST_K_RD_J: begin
        s_addr      = r_j;
        w_state_nxt = ST_K_CAP_J;
      end
      ST_K_CAP_J: w_state_nxt = ST_K_WR_I;
      ST_K_WR_I: begin
        s_addr      = r_i;
        s_wdata     = r_sj;
        s_wren      = 1'b1;
        w_state_nxt = ST_K_WR_J;
      end
      ST_K_WR_J: begin
        s_addr      = r_j;
        s_wdata     = r_si;
        s_wren      = 1'b1;
        w_state_nxt = (r_i == 8'd255) ? ST_P_RD_I : ST_K_RD_I;
      end
      ST_P_RD_I: begin
        s_addr      = r_i;
        w_state_nxt = ST_P_CAP_I;
      end
      ST_P_CAP_I: w_state_nxt = ST_P_RD_J;
      ST_P_RD_J: begin
        s_addr      = r_j;
        w_state_nxt = ST_P_CAP_J;
      end
      ST_P_CAP_J: w_state_nxt = ST_P_WR_I;
      ST_P_WR_I: begin
        s_addr      = r_i;
        s_wdata     = r_sj;
        s_wren      = 1'b1;
        w_state_nxt = ST_P_WR_J;
      end
      ST_P_WR_J: begin
        s_addr      = r_j;
        s_wdata     = r_si;
        s_wren      = 1'b1;
        w_state_nxt = ST_P_RD_F;
      end
      ST_P_RD_F: begin
        // Post-swap s[i]+s[j] equals pre-swap r_si+r_sj, so no re-read is needed.
        s_addr      = r_si + r_sj;
        pt_addr     = r_k;
        w_state_nxt = ST_P_CAP_F;
      end
      ST_P_CAP_F: w_state_nxt = ST_P_WR_CT;
      ST_P_WR_CT: begin
        ct_addr     = r_k;
        ct_wdata    = r_ct;
        ct_wren     = 1'b1;
        w_state_nxt = (r_k == LP_LAST_K) ? ST_DONE : ST_P_RD_I;
      end
      ST_DONE: begin
        finish      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: the key latch, the i/j/k indices and the captured S and ciphertext bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key  <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_kidx <= '0;
      r_si   <= '0;
      r_sj   <= '0;
      r_ct   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_key  <= key;
            r_i    <= '0;
            r_j    <= '0;
            r_k    <= '0;
            r_kidx <= '0;
          end
        end
        ST_INIT: r_i <= r_i + 8'd1;
        ST_K_CAP_I: begin
          r_si <= s_rdata;
          r_j  <= r_j + s_rdata + w_kbyte;
        end
        ST_K_CAP_J: r_sj <= s_rdata;
        ST_K_WR_J: begin
          r_kidx <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
          if (r_i == 8'd255) begin
            // PRGA starts from i=0 and increments i before the first read, so i is loaded as 1.
            r_i <= 8'd1;
            r_j <= '0;
          end else begin
            r_i <= r_i + 8'd1;
          end
        end
        ST_P_CAP_I: begin
          r_si <= s_rdata;
          r_j  <= r_j + s_rdata;
        end
        ST_P_CAP_J: r_sj <= s_rdata;
        ST_P_CAP_F: r_ct <= s_rdata ^ pt_rdata;
        ST_P_WR_CT: begin
          r_k <= r_k + 1'b1;
          r_i <= r_i + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_encryptor.sv
// Self-checking bench for rc4_encryptor. It models the S, plaintext and
// ciphertext memories, and it compares results against a plain software RC4
// model.
module tb_rc4_encryptor;

  localparam int unsigned MSG_LEN = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int          MAX_LAT = 256 + 256 * 8 + MSG_LEN * 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [23:0]       key;
  logic              ready;
  logic              finish;
  logic [7:0]        s_addr;
  logic [7:0]        s_wdata;
  logic              s_wren;
  logic [7:0]        s_rdata;
  logic [ADDR_W-1:0] pt_addr;
  logic [7:0]        pt_rdata;
  logic [ADDR_W-1:0] ct_addr;
  logic [7:0]        ct_wdata;
  logic              ct_wren;

  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [MSG_LEN];
  logic [7:0] ct_mem [MSG_LEN];
  logic [7:0] m_s    [256];
  logic [7:0] m_ct   [MSG_LEN];
  logic [7:0] orig   [MSG_LEN];

  int n_checks = 0;
  int n_errors = 0;

  // Monitor totals, written only by the monitor process.
  int ct_total = 0;
  int s_wr_total = 0;
  int fin_total = 0;
  int ct_addr_err = 0;
  int fin_order_err = 0;
  int mon_exp_addr = 0;
  bit prev_ct = 1'b0;

  rc4_encryptor #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key      (key),
    .ready    (ready),
    .finish   (finish),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wren   (s_wren),
    .s_rdata  (s_rdata),
    .pt_addr  (pt_addr),
    .pt_rdata (pt_rdata),
    .ct_addr  (ct_addr),
    .ct_wdata (ct_wdata),
    .ct_wren  (ct_wren)
  );

  always #5 clk = ~clk;

  // Synchronous memories with a 1-cycle read latency.
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wdata;
    s_rdata  <= s_mem[s_addr];
    pt_rdata <= pt_mem[pt_addr];
    if (ct_wren) ct_mem[ct_addr] <= ct_wdata;
  end

  // Tracks ciphertext write ordering and finish placement.
  always @(negedge clk) begin
    if (ready) mon_exp_addr = 0;
    if (s_wren) s_wr_total++;
    if (ct_wren) begin
      if (int'(ct_addr) != mon_exp_addr) ct_addr_err++;
      mon_exp_addr++;
      ct_total++;
    end
    if (finish) begin
      fin_total++;
      if (!prev_ct) fin_order_err++;
    end
    prev_ct = ct_wren;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference RC4 over the current pt_mem.
  task automatic ref_model(input logic [23:0] kk);
    logic [7:0] i, j, t, kb;
    for (int n = 0; n < 256; n++) m_s[n] = 8'(n);
    j = 0;
    for (int n = 0; n < 256; n++) begin
      kb = (n % 3 == 0) ? kk[23:16] : (n % 3 == 1) ? kk[15:8] : kk[7:0];
      j = j + m_s[n] + kb;
      t = m_s[n]; m_s[n] = m_s[j]; m_s[j] = t;
    end
    i = 0; j = 0;
    for (int n = 0; n < int'(MSG_LEN); n++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      t = m_s[i] + m_s[j];
      m_ct[n] = m_s[t] ^ pt_mem[n];
    end
  endtask

  task automatic compare_model(input string tag, input bit with_s);
    int bad;
    for (int n = 0; n < int'(MSG_LEN); n++) check($sformatf("%s_ct%0d", tag, n), {24'd0, ct_mem[n]}, {24'd0, m_ct[n]});
    if (with_s) begin
      bad = 0;
      for (int n = 0; n < 256; n++) if (s_mem[n] !== m_s[n]) bad++;
      check({tag, "_sfinal_mism"}, bad, 0);
    end
  endtask

  // One full run. A nonzero inject_at pulses start with key k2 at that cycle.
  task automatic run_enc(input string tag, input logic [23:0] k, input int inject_at,
                         input logic [23:0] k2, output int lat);
    int cyc, ct0, fin0, aerr0, ferr0, bad;
    int seen [256];
    cyc = 0;
    while (!ready && cyc < 100) begin @(negedge clk); cyc++; end
    check({tag, "_ready_pre"}, ready, 1);
    ct0 = ct_total; fin0 = fin_total; aerr0 = ct_addr_err; ferr0 = fin_order_err;
    key = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key = 24'($urandom);
    check({tag, "_accept_ready"}, ready, 0);
    check({tag, "_init0"}, {s_wren, s_addr, s_wdata}, {1'b1, 8'd0, 8'd0});
    cyc = 1;
    while (!finish && cyc < 5000) begin
      if (cyc == 257) begin
        for (int n = 0; n < 256; n++) seen[n] = 0;
        for (int n = 0; n < 256; n++) seen[s_mem[n]]++;
        bad = 0;
        for (int n = 0; n < 256; n++) if (seen[n] != 1) bad++;
        check({tag, "_init_perm"}, bad, 0);
      end
      if (inject_at != 0 && cyc == inject_at) begin
        check({tag, "_inject_busy"}, ready, 0);
        start = 1'b1; key = k2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_finish_seen"}, finish, 1);
    lat = cyc;
    check({tag, "_lat_bound"}, (lat <= MAX_LAT), 1);
    @(negedge clk);
    check({tag, "_ready_post"}, {ready, finish}, 2'b10);
    check({tag, "_ct_pulses"}, ct_total - ct0, MSG_LEN);
    check({tag, "_fin_pulses"}, fin_total - fin0, 1);
    check({tag, "_ct_order"}, ct_addr_err - aerr0, 0);
    check({tag, "_fin_after_ct"}, fin_order_err - ferr0, 0);
  endtask

  logic [7:0] kv_ct [9];
  logic [7:0] kv_pt [9];

  initial begin
    int lat_solo, lat, bad, c;
    logic [23:0] ka;
    kv_pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    kv_ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    reset = 1'b1; start = 1'b0; key = '0;
    for (int n = 0; n < int'(MSG_LEN); n++) pt_mem[n] = '0;

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_outputs", {s_addr, s_wdata, 3'(pt_addr), 3'(ct_addr), ct_wdata}, '0);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      if ({ready, finish, s_wren, ct_wren} !== 4'b1000) bad++;
      @(negedge clk);
    end
    check("rst_idle_10", bad, 0);

    // Known vector: the first 9 bytes are "Plaintext"
    for (int n = 0; n < int'(MSG_LEN); n++) pt_mem[n] = (n < 9) ? kv_pt[n] : 8'($urandom);
    ref_model(24'h4B6579);
    run_enc("kv", 24'h4B6579, 0, '0, lat_solo);
    for (int n = 0; n < 9; n++) check($sformatf("kv_const%0d", n), {24'd0, ct_mem[n]}, {24'd0, kv_ct[n]});
    compare_model("kv", 1'b1);

    // Round trip with a zero key
    for (int n = 0; n < int'(MSG_LEN); n++) begin pt_mem[n] = 8'($urandom); orig[n] = pt_mem[n]; end
    ref_model(24'h000000);
    run_enc("rt1", 24'h000000, 0, '0, lat);
    check("rt1_latency", lat, lat_solo);
    compare_model("rt1", 1'b1);
    for (int n = 0; n < int'(MSG_LEN); n++) pt_mem[n] = ct_mem[n];
    run_enc("rt2", 24'h000000, 0, '0, lat);
    for (int n = 0; n < int'(MSG_LEN); n++) check($sformatf("rt2_pt%0d", n), {24'd0, ct_mem[n]}, {24'd0, orig[n]});

    // All-ones key
    for (int n = 0; n < int'(MSG_LEN); n++) pt_mem[n] = 8'($urandom);
    ref_model(24'hFFFFFF);
    run_enc("ff", 24'hFFFFFF, 0, '0, lat);
    compare_model("ff", 1'b1);

    // A start pulse with another key during KSA is ignored
    ka = 24'($urandom);
    for (int n = 0; n < int'(MSG_LEN); n++) pt_mem[n] = 8'($urandom);
    ref_model(ka);
    run_enc("hs", ka, 600, ~ka, lat);
    check("hs_latency", lat, lat_solo);
    compare_model("hs", 1'b1);

    // Reset after the 5th ciphertext write
    ka = 24'($urandom);
    key = ka; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0; lat = 0;
    while (c < 5 && lat < 5000) begin
      if (ct_wren) c++;
      if (c < 5) begin @(negedge clk); lat++; end
    end
    check("mid_fifth_seen", c, 5);
    reset = 1'b1;
    @(negedge clk);
    check("mid_ready_next", ready, 1);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      if (s_wren || ct_wren || !ready) bad++;
      @(negedge clk);
    end
    check("mid_quiet", bad, 0);
    for (int n = 0; n < int'(MSG_LEN); n++) pt_mem[n] = (n < 9) ? kv_pt[n] : 8'($urandom);
    ref_model(24'h4B6579);
    run_enc("kv2", 24'h4B6579, 0, '0, lat);
    check("kv2_latency", lat, lat_solo);
    for (int n = 0; n < 9; n++) check($sformatf("kv2_const%0d", n), {24'd0, ct_mem[n]}, {24'd0, kv_ct[n]});
    compare_model("kv2", 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
